// File: rtl/axi_w_alloc_pkg.sv
// Shared types and helpers for the AXI W-channel data allocator.
// AXI_W_BEAT_STRUCT builds the beat struct for any data/user width.
package axi_w_alloc_pkg;

    localparam int SKID_DEPTH = 2;

    // Pointer width for a FIFO of depth v; never narrower than one bit.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

`ifndef AXI_W_BEAT_STRUCT
`define AXI_W_BEAT_STRUCT(DW, UW) struct packed { \
    logic [(DW)-1:0]   data; \
    logic [(DW)/8-1:0] strb; \
    logic              last; \
    logic [(UW)-1:0]   user; \
}
`endif

// File: rtl/axi_w_id_fifo.sv
// Generic synchronous FIFO: holds AW grant IDs or, in the top, skid beats.
// Latency: no fall-through, a pushed entry is at the head one cycle later at the earliest.
// Backpressure: push dropped while full (even with a same-cycle pop), pop ignored while empty.
module axi_w_id_fifo
    import axi_w_alloc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            push_data,
    output logic [WIDTH-1:0]            data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2_safe(DEPTH):0]  count
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign data    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_w_data_allocator.sv
// Init-side W merger: forwards bursts from N target ports in AW grant order (AXI_W_ALLOC_SKID_EN adds a skid).
// Latency: 0 cycles combinational; 1 cycle when AXI_W_ALLOC_SKID_EN is defined.
// Backpressure: only the head port sees wready; with the skid, wready_o is cut from wready_i.
module axi_w_data_allocator
    import axi_w_alloc_pkg::*;
#(
    parameter int N_TARG_PORT = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              test_en_i,
    input  logic                              push_ID_i,
    input  logic [N_TARG_PORT-1:0]            ID_i,
    output logic                              grant_FIFO_ID_o,
    input  logic [N_TARG_PORT*AXI_DATA_W-1:0] wdata_i,
    input  logic [N_TARG_PORT*AXI_DATA_W/8-1:0] wstrb_i,
    input  logic [N_TARG_PORT-1:0]            wlast_i,
    input  logic [N_TARG_PORT*AXI_USER_W-1:0] wuser_i,
    input  logic [N_TARG_PORT-1:0]            wvalid_i,
    output logic [N_TARG_PORT-1:0]            wready_o,
    output logic [AXI_DATA_W-1:0]             wdata_o,
    output logic [AXI_DATA_W/8-1:0]           wstrb_o,
    output logic                              wlast_o,
    output logic [AXI_USER_W-1:0]             wuser_o,
    output logic                              wvalid_o,
    input  logic                              wready_i
);

    localparam int DW = AXI_DATA_W;
    localparam int SW = AXI_DATA_W / 8;
    localparam int UW = AXI_USER_W;
    localparam int CW = clog2_safe(FIFO_DEPTH) + 1;

    typedef `AXI_W_BEAT_STRUCT(AXI_DATA_W, AXI_USER_W) w_beat_t;
    localparam int BW = $bits(w_beat_t);

    logic [N_TARG_PORT-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          id_count;
    logic                   pop;
    logic                   out_ready;
    logic [N_TARG_PORT-1:0] sel_mask;
    logic                   sel_valid;
    w_beat_t                sel_beat;
    w_beat_t                out_beat;

    axi_w_id_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (N_TARG_PORT)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ID_i),
        .pop       (pop),
        .push_data (ID_i),
        .data      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (id_count)
    );

    assign grant_FIFO_ID_o = ~fifo_full;

    assign sel_mask  = wvalid_i & head & {N_TARG_PORT{~fifo_empty}};
    assign sel_valid = |sel_mask;
    assign pop       = |(sel_mask & wlast_i) & out_ready;
    assign wready_o  = head & {N_TARG_PORT{~fifo_empty & out_ready}};

    // One-hot AND-OR mux; an idle or absent head yields an all-zero beat.
    always_comb begin
        sel_beat = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            sel_beat.data = sel_beat.data | ({DW{sel_mask[i]}} & wdata_i[i*DW +: DW]);
            sel_beat.strb = sel_beat.strb | ({SW{sel_mask[i]}} & wstrb_i[i*SW +: SW]);
            sel_beat.last = sel_beat.last | (sel_mask[i] & wlast_i[i]);
            sel_beat.user = sel_beat.user | ({UW{sel_mask[i]}} & wuser_i[i*UW +: UW]);
        end
    end

`ifdef AXI_W_ALLOC_SKID_EN
    logic                            skid_full;
    logic                            skid_empty;
    logic [clog2_safe(SKID_DEPTH):0] skid_count;
    logic [BW-1:0]                   skid_data;

    // Accept only while the skid has room, keeping wready_i out of the wready_o cone.
    axi_w_id_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (BW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (sel_valid & out_ready),
        .pop       (wready_i),
        .push_data (sel_beat),
        .data      (skid_data),
        .full      (skid_full),
        .empty     (skid_empty),
        .count     (skid_count)
    );

    assign out_ready = ~skid_full;
    assign wvalid_o  = ~skid_empty;
    assign out_beat  = w_beat_t'(skid_data);

    logic unused_skid;
    assign unused_skid = ^skid_count;
`else
    assign out_ready = wready_i;
    assign wvalid_o  = sel_valid;
    assign out_beat  = sel_beat;
`endif

    assign wdata_o = out_beat.data;
    assign wstrb_o = out_beat.strb;
    assign wlast_o = out_beat.last;
    assign wuser_o = out_beat.user;

    logic unused_sig;
    assign unused_sig = ^{test_en_i, id_count};

    a_id_onehot: assert property (@(posedge clk) disable iff (rst) push_ID_i |-> $onehot(ID_i));

endmodule

// File: tb/tb_axi_w_data_allocator.sv
// Directed bench for axi_w_data_allocator (default build, combinational data path).
module tb_axi_w_data_allocator;

    localparam int N  = 8;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int UW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            test_en_i;
    logic            push_ID_i;
    logic [N-1:0]    ID_i;
    logic            grant_FIFO_ID_o;
    logic [N*DW-1:0] wdata_i;
    logic [N*SW-1:0] wstrb_i;
    logic [N-1:0]    wlast_i;
    logic [N*UW-1:0] wuser_i;
    logic [N-1:0]    wvalid_i;
    logic [N-1:0]    wready_o;
    logic [DW-1:0]   wdata_o;
    logic [SW-1:0]   wstrb_o;
    logic            wlast_o;
    logic [UW-1:0]   wuser_o;
    logic            wvalid_o;
    logic            wready_i;

    logic [DW-1:0] t_data  [N];
    logic [SW-1:0] t_strb  [N];
    logic [UW-1:0] t_user  [N];
    logic          t_last  [N];
    logic          t_valid [N];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [DW-1:0] mon_data [$];
    logic          mon_last [$];
    logic [SW-1:0] mon_strb [$];
    logic [UW-1:0] mon_user [$];
    int            mon_cyc  [$];

    axi_w_data_allocator #(
        .N_TARG_PORT (N),
        .FIFO_DEPTH  (8),
        .AXI_DATA_W  (DW),
        .AXI_USER_W  (UW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .test_en_i       (test_en_i),
        .push_ID_i       (push_ID_i),
        .ID_i            (ID_i),
        .grant_FIFO_ID_o (grant_FIFO_ID_o),
        .wdata_i         (wdata_i),
        .wstrb_i         (wstrb_i),
        .wlast_i         (wlast_i),
        .wuser_i         (wuser_i),
        .wvalid_i        (wvalid_i),
        .wready_o        (wready_o),
        .wdata_o         (wdata_o),
        .wstrb_o         (wstrb_o),
        .wlast_o         (wlast_o),
        .wuser_o         (wuser_o),
        .wvalid_o        (wvalid_o),
        .wready_i        (wready_i)
    );

    always #5 clk = ~clk;

    always_comb begin
        wdata_i  = '0;
        wstrb_i  = '0;
        wuser_i  = '0;
        wlast_i  = '0;
        wvalid_i = '0;
        for (int i = 0; i < N; i++) begin
            wdata_i[i*DW +: DW] = t_data[i];
            wstrb_i[i*SW +: SW] = t_strb[i];
            wuser_i[i*UW +: UW] = t_user[i];
            wlast_i[i]          = t_last[i];
            wvalid_i[i]         = t_valid[i];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && wvalid_o && wready_i) begin
            mon_data.push_back(wdata_o);
            mon_last.push_back(wlast_o);
            mon_strb.push_back(wstrb_o);
            mon_user.push_back(wuser_o);
            mon_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] bd(input int p, input int b);
        return 64'hD000_0000_0000_0000 | (64'(p) << 8) | 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic mon_clear();
        mon_data.delete();
        mon_last.delete();
        mon_strb.delete();
        mon_user.delete();
        mon_cyc.delete();
    endtask

    task automatic chk_beat(input string tag, input int idx, input int p, input int b, input bit last);
        if (idx < mon_data.size()) begin
            check({tag, "_data"}, mon_data[idx], bd(p, b));
            check({tag, "_last"}, 64'(mon_last[idx]), 64'(last));
        end else begin
            check({tag, "_missing"}, 64'hDEAD, bd(p, b));
        end
    endtask

    // All tasks start and end just after a rising edge.
    task automatic push_id(input logic [N-1:0] id);
        push_ID_i = 1'b1;
        ID_i      = id;
        @(posedge clk); #1;
        push_ID_i = 1'b0;
        ID_i      = '0;
    endtask

    task automatic send_beat(input int p, input int b, input bit last);
        bit ok;
        ok         = 1'b0;
        t_data[p]  = bd(p, b);
        t_strb[p]  = SW'(1 << p);
        t_user[p]  = UW'(p + 1);
        t_last[p]  = last;
        t_valid[p] = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (wready_o[p]) ok = 1'b1;
            @(posedge clk); #1;
        end
        t_valid[p] = 1'b0;
        t_last[p]  = 1'b0;
        if (!ok) check($sformatf("timeout_p%0d_b%0d", p, b), 64'd0, 64'd1);
    endtask

    task automatic send_burst(input int p, input int n);
        for (int b = 0; b < n; b++) send_beat(p, b, b == n - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        test_en_i = 1'b0;
        push_ID_i = 1'b0;
        ID_i      = '0;
        wready_i  = 1'b1;
        for (int i = 0; i < N; i++) begin
            t_data[i] = '0; t_strb[i] = '0; t_user[i] = '0; t_last[i] = 1'b0; t_valid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then traffic on every port with nothing granted.
        @(negedge clk);
        check("rst_wvalid", 64'(wvalid_o), 64'd0);
        check("rst_grant", 64'(grant_FIFO_ID_o), 64'd1);
        check("rst_wready", 64'(wready_o), 64'd0);
        check("rst_count", 64'(dut.id_count), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin t_valid[i] = 1'b1; t_last[i] = 1'b1; end
        @(negedge clk);
        check("empty_wvalid", 64'(wvalid_o), 64'd0);
        check("empty_wready", 64'(wready_o), 64'd0);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin t_valid[i] = 1'b0; t_last[i] = 1'b0; end
        check("empty_nobeat", 64'(mon_data.size()), 64'd0);

        // Reset in the middle of a 4-beat burst from port 2.
        mon_clear();
        push_id(8'h04);
        send_beat(2, 0, 1'b0);
        send_beat(2, 1, 1'b0);
        check("midrst_beats", 64'(mon_data.size()), 64'd2);
        t_data[2] = bd(2, 2); t_valid[2] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_wvalid", 64'(wvalid_o), 64'd0);
        check("midrst_grant", 64'(grant_FIFO_ID_o), 64'd1);
        check("midrst_count", 64'(dut.id_count), 64'd0);
        check("midrst_wready", 64'(wready_o), 64'd0);
        @(posedge clk); #1;
        t_valid[2] = 1'b0;
        check("midrst_noextra", 64'(mon_data.size()), 64'd2);

        // Ordering: port1 granted first, port0 waits for port1's wlast.
        mon_clear();
        push_id(8'h02);
        push_id(8'h01);
        fork
            send_burst(0, 3);
            send_burst(1, 3);
            begin
                @(negedge clk);
                check("ord_first_rdy", 64'(wready_o), 64'h02);
            end
        join
        check("ord_n", 64'(mon_data.size()), 64'd6);
        for (int b = 0; b < 3; b++) chk_beat($sformatf("ord_p1b%0d", b), b, 1, b, b == 2);
        for (int b = 0; b < 3; b++) chk_beat($sformatf("ord_p0b%0d", b), b + 3, 0, b, b == 2);
        check("ord_count", 64'(dut.id_count), 64'd0);

        // Full: 8 grants, 9th push coincides with a pop and is dropped.
        mon_clear();
        for (int i = 0; i < N; i++) push_id(8'(1 << i));
        check("full_grant", 64'(grant_FIFO_ID_o), 64'd0);
        check("full_count", 64'(dut.id_count), 64'd8);
        t_data[0] = bd(0, 0); t_strb[0] = 8'h01; t_user[0] = 6'd1; t_last[0] = 1'b1; t_valid[0] = 1'b1;
        push_ID_i = 1'b1; ID_i = 8'h80;
        @(negedge clk);
        check("full_pop_rdy", 64'(wready_o), 64'h01);
        @(posedge clk); #1;
        push_ID_i = 1'b0; ID_i = '0; t_valid[0] = 1'b0; t_last[0] = 1'b0;
        check("full_after_pop", 64'(dut.id_count), 64'd7);
        check("full_grant_back", 64'(grant_FIFO_ID_o), 64'd1);
        for (int p = 1; p < N; p++) send_beat(p, 0, 1'b1);
        check("full_drained", 64'(dut.id_count), 64'd0);
        check("full_n", 64'(mon_data.size()), 64'd8);
        chk_beat("full_last", 7, 7, 0, 1'b1);

        // Backpressure: wready_i low for 5 cycles after the first beat.
        mon_clear();
        push_id(8'h08);
        fork
            send_burst(3, 4);
            begin
                @(posedge clk); #1;
                wready_i = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_hold%0d", k), {wdata_o[62:0], wvalid_o}, {bd(3, 1)[62:0], 1'b1});
                    check($sformatf("bp_rdy%0d", k), 64'(wready_o), 64'd0);
                    @(posedge clk); #1;
                end
                wready_i = 1'b1;
            end
        join
        check("bp_n", 64'(mon_data.size()), 64'd4);
        for (int b = 0; b < 4; b++) chk_beat($sformatf("bp_b%0d", b), b, 3, b, b == 3);

        // Simultaneous push and pop at count 3.
        mon_clear();
        push_id(8'h01);
        push_id(8'h02);
        push_id(8'h04);
        check("pp_count_pre", 64'(dut.id_count), 64'd3);
        t_data[0] = bd(0, 0); t_last[0] = 1'b1; t_valid[0] = 1'b1;
        push_ID_i = 1'b1; ID_i = 8'h10;
        @(negedge clk);
        check("pp_rdy", 64'(wready_o), 64'h01);
        @(posedge clk); #1;
        push_ID_i = 1'b0; ID_i = '0; t_valid[0] = 1'b0; t_last[0] = 1'b0;
        check("pp_count", 64'(dut.id_count), 64'd3);
        fork
            send_beat(4, 0, 1'b1);
            send_beat(2, 0, 1'b1);
            send_beat(1, 0, 1'b1);
        join
        check("pp_n", 64'(mon_data.size()), 64'd4);
        chk_beat("pp_0", 0, 0, 0, 1'b1);
        chk_beat("pp_1", 1, 1, 0, 1'b1);
        chk_beat("pp_2", 2, 2, 0, 1'b1);
        chk_beat("pp_3", 3, 4, 0, 1'b1);

        // Throughput: back-to-back single-beat bursts from ports 0,3,5,7.
        mon_clear();
        push_id(8'h01);
        push_id(8'h08);
        push_id(8'h20);
        push_id(8'h80);
        fork
            send_beat(7, 0, 1'b1);
            send_beat(5, 0, 1'b1);
            send_beat(3, 0, 1'b1);
            send_beat(0, 0, 1'b1);
        join
        check("tp_n", 64'(mon_data.size()), 64'd4);
        chk_beat("tp_0", 0, 0, 0, 1'b1);
        chk_beat("tp_1", 1, 3, 0, 1'b1);
        chk_beat("tp_2", 2, 5, 0, 1'b1);
        chk_beat("tp_3", 3, 7, 0, 1'b1);
        if (mon_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check($sformatf("tp_gap%0d", i), 64'(mon_cyc[i] - mon_cyc[i-1]), 64'd1);
            check("tp_strb", 64'(mon_strb[2]), 64'h20);
            check("tp_user", 64'(mon_user[3]), 64'd8);
        end else begin
            check("tp_cyc_n", 64'(mon_cyc.size()), 64'd4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
